// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its safety monitor.
// The phase encoding must stay identical to the controller's 2-bit phase register.
package traffic_pkg;

  typedef enum logic [1:0] {
    NS_G = 2'd0,
    NS_Y = 2'd1,
    EW_G = 2'd2,
    EW_Y = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FAULT  = 2'd1,
    RESYNC = 2'd2
  } mon_state_t;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_ILLEGAL  = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE = 3'd3;
  localparam logic [2:0] CODE_EARLY    = 3'd4;
  localparam logic [2:0] CODE_STUCK    = 3'd5;

  // Lamp vectors ordered {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
  localparam logic [5:0] LAMPS_NS_G = 6'b100_001;
  localparam logic [5:0] LAMPS_NS_Y = 6'b010_001;
  localparam logic [5:0] LAMPS_EW_G = 6'b001_100;
  localparam logic [5:0] LAMPS_EW_Y = 6'b001_010;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Classifies the six lamp outputs into one of the four legal phases,
// a conflicting-green condition, or an otherwise illegal pattern.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  output logic       conflict,
  output logic       illegal,
  output logic [1:0] phase
);

  logic [5:0] lamps;

  always_comb begin
    lamps    = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    conflict = (ns_g | ns_y) & (ew_g | ew_y);
    illegal  = 1'b0;
    phase    = NS_G;
    case (lamps)
      LAMPS_NS_G: phase = NS_G;
      LAMPS_NS_Y: phase = NS_Y;
      LAMPS_EW_G: phase = EW_G;
      LAMPS_EW_Y: phase = EW_Y;
      // A conflicting pattern is reported only as a conflict, never also as illegal.
      default:    illegal = ~conflict;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's lamps: flags conflicts, illegal patterns,
// out-of-order phases and wrong phase durations, then requests yellow flashing.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          ns_g,
  input  logic          ns_y,
  input  logic          ns_r,
  input  logic          ew_g,
  input  logic          ew_y,
  input  logic          ew_r,
  input  logic          fault_clr,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic [1:0]    phase,
  output logic [CW-1:0] tick_cnt,
  output logic          flash_y
);

  localparam logic [CW-1:0] GREEN_REQ  = CW'(GREEN_TICKS);
  localparam logic [CW-1:0] YELLOW_REQ = CW'(YELLOW_TICKS);

  mon_state_t    state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    code_reg, code_next;
  logic          flash_reg, flash_next;
  logic          prev_nsg_reg;

  logic          dec_conflict;
  logic          dec_illegal;
  logic [1:0]    dec_phase_raw;
  phase_t        dec_phase;
  phase_t        succ_phase;
  logic          dec_nsg;
  logic [CW-1:0] req_cnt;
  logic [CW-1:0] tick_ext;
  logic [2:0]    violation;

  lamp_decode u_decode (
    .ns_g     (ns_g),
    .ns_y     (ns_y),
    .ns_r     (ns_r),
    .ew_g     (ew_g),
    .ew_y     (ew_y),
    .ew_r     (ew_r),
    .conflict (dec_conflict),
    .illegal  (dec_illegal),
    .phase    (dec_phase_raw)
  );

  always_comb begin
    dec_phase  = phase_t'(dec_phase_raw);
    succ_phase = next_phase(phase_reg);
    dec_nsg    = ~dec_conflict & ~dec_illegal & (dec_phase == NS_G);
    req_cnt    = ((phase_reg == NS_G) || (phase_reg == EW_G)) ? GREEN_REQ : YELLOW_REQ;
    tick_ext   = {{(CW-1){1'b0}}, tick};
  end

  // Run-state checks, first match wins.
  always_comb begin
    violation = CODE_NONE;
    if (dec_conflict)
      violation = CODE_CONFLICT;
    else if (dec_illegal)
      violation = CODE_ILLEGAL;
    else if ((dec_phase != phase_reg) && (dec_phase != succ_phase))
      violation = CODE_SEQUENCE;
    else if ((dec_phase == succ_phase) && (cnt_reg != req_cnt))
      violation = CODE_EARLY;
    else if ((dec_phase == phase_reg) && tick && (cnt_reg == req_cnt))
      violation = CODE_STUCK;
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    flash_next = flash_reg;
    case (state_reg)
      RUN: begin
        if (violation != CODE_NONE) begin
          state_next = FAULT;
          code_next  = violation;
          flash_next = 1'b1;
        end else if (dec_phase == succ_phase) begin
          // The controller advanced on the previous edge, so this tick is the new phase's.
          phase_next = dec_phase;
          cnt_next   = tick_ext;
        end else begin
          cnt_next   = cnt_reg + tick_ext;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_next = RESYNC;
          code_next  = CODE_NONE;
          flash_next = 1'b0;
          cnt_next   = '0;
        end else if (tick) begin
          flash_next = ~flash_reg;
        end
      end
      RESYNC: begin
        if (dec_conflict || dec_illegal) begin
          state_next = FAULT;
          code_next  = dec_conflict ? CODE_CONFLICT : CODE_ILLEGAL;
          flash_next = 1'b1;
        end else if (dec_nsg && !prev_nsg_reg) begin
          // Only a fresh entry into NS_G gives a trustworthy phase boundary.
          state_next = RUN;
          phase_next = NS_G;
          cnt_next   = tick_ext;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      phase_reg    <= NS_G;
      cnt_reg      <= '0;
      code_reg     <= CODE_NONE;
      flash_reg    <= 1'b0;
      prev_nsg_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      cnt_reg      <= cnt_next;
      code_reg     <= code_next;
      flash_reg    <= flash_next;
      prev_nsg_reg <= dec_nsg;
    end
  end

  assign fault      = (state_reg == FAULT);
  assign fault_code = code_reg;
  assign phase      = phase_reg;
  assign tick_cnt   = cnt_reg;
  assign flash_y    = flash_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: pattern table, directed corner sequences and
// a randomized run against a controller model and a rule-level reference model.
module tb_traffic_light_monitor;

  localparam int GT = 5;
  localparam int YT = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n, tick, fault_clr;
  logic          ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic          fault;
  logic [2:0]    fault_code;
  logic [1:0]    phase;
  logic [CW-1:0] tick_cnt;
  logic          flash_y;

  always #5 clk = ~clk;

  traffic_light_monitor #(.GREEN_TICKS(GT), .YELLOW_TICKS(YT), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .ns_g       (ns_g),
    .ns_y       (ns_y),
    .ns_r       (ns_r),
    .ew_g       (ew_g),
    .ew_y       (ew_y),
    .ew_r       (ew_r),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .phase      (phase),
    .tick_cnt   (tick_cnt),
    .flash_y    (flash_y)
  );

  typedef struct {
    logic [5:0] lamps;
    logic       tck;
    logic       exp_fault;
    logic [2:0] exp_code;
    logic [1:0] exp_phase;
    logic [2:0] exp_cnt;
  } vec_t;

  localparam logic [5:0] P_NSG = 6'b100_001;
  localparam logic [5:0] P_NSY = 6'b010_001;
  localparam logic [5:0] P_EWG = 6'b001_100;
  localparam logic [5:0] P_EWY = 6'b001_010;
  localparam logic [5:0] P_RED = 6'b001_001;
  localparam logic [5:0] P_CON = 6'b100_101;

  int         checks = 0;
  int         errors = 0;
  int         req_t [4];
  logic [5:0] pat [4];
  vec_t       vec [12];

  // Reference model: mode 0 monitoring, 1 faulted, 2 waiting to resync.
  int m_mode, m_phase, m_cnt, m_code;
  bit m_flash, m_prev_nsg;
  // Controller model.
  int c_phase, c_cnt;

  function automatic int decode(input logic [5:0] l);
    for (int i = 0; i < 4; i++)
      if (l == pat[i]) return i;
    return -1;
  endfunction

  function automatic bit conflicting(input logic [5:0] l);
    return (l[5] | l[4]) & (l[2] | l[1]);
  endfunction

  task automatic model_step(input logic [5:0] l, input bit t, input bit clr, input bit rst);
    int d, code, nxt;
    bit conf;
    d    = decode(l);
    conf = conflicting(l);
    if (!rst) begin
      m_mode = 0; m_phase = 0; m_cnt = 0; m_code = 0; m_flash = 0; m_prev_nsg = 0;
      return;
    end
    if (m_mode == 0) begin
      nxt  = (m_phase + 1) % 4;
      code = 0;
      if (conf) code = 1;
      else if (d < 0) code = 2;
      else if (d != m_phase && d != nxt) code = 3;
      else if (d == nxt && m_cnt != req_t[m_phase]) code = 4;
      else if (d == m_phase && t && m_cnt == req_t[m_phase]) code = 5;
      if (code != 0) begin
        m_mode = 1; m_code = code; m_flash = 1;
      end else if (d == nxt) begin
        m_phase = d; m_cnt = int'(t);
      end else begin
        m_cnt = m_cnt + int'(t);
      end
    end else if (m_mode == 1) begin
      if (clr) begin
        m_mode = 2; m_code = 0; m_flash = 0; m_cnt = 0;
      end else if (t) begin
        m_flash = !m_flash;
      end
    end else begin
      if (conf || d < 0) begin
        m_mode = 1; m_code = conf ? 1 : 2; m_flash = 1;
      end else if (d == 0 && !m_prev_nsg) begin
        m_mode = 0; m_phase = 0; m_cnt = int'(t);
      end
    end
    m_prev_nsg = (d == 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] l, input bit t, input bit clr, input bit rst);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = l;
    tick      = t;
    fault_clr = clr;
    rst_n     = rst;
    model_step(l, t, clr, rst);
    @(negedge clk);
    checks++;
    if (fault !== (m_mode == 1) || fault_code !== 3'(m_code) || phase !== 2'(m_phase) ||
        tick_cnt !== CW'(m_cnt) || flash_y !== m_flash) begin
      errors++;
      $display("FAIL model t=%0t lamps=%b tick=%0b clr=%0b: got f=%0b c=%0d p=%0d n=%0d y=%0b expected f=%0b c=%0d p=%0d n=%0d y=%0b",
               $time, l, t, clr, fault, fault_code, phase, tick_cnt, flash_y,
               m_mode == 1, m_code, m_phase, m_cnt, m_flash);
    end
  endtask

  task automatic ctrl_step(input bit t, input bit clr, input bit rst, input bit glitch);
    logic [5:0] l;
    l = pat[c_phase];
    if (glitch) l = 6'($urandom_range(0, 63));
    step(l, t, clr, rst);
    if (!rst) begin
      c_phase = 0; c_cnt = 0;
    end else if (t) begin
      c_cnt++;
      if (c_cnt == req_t[c_phase]) begin
        c_phase = (c_phase + 1) % 4; c_cnt = 0;
      end
    end
  endtask

  task automatic reset_all();
    ctrl_step(0, 0, 0, 0);
  endtask

  initial begin
    int peak [4];
    int last_phase;
    bit any_fault;
    req_t = '{GT, YT, GT, YT};
    pat   = '{P_NSG, P_NSY, P_EWG, P_EWY};
    vec[0]  = '{P_NSG,     1'b0, 1'b0, 3'd0, 2'd0, 3'd0};
    vec[1]  = '{P_NSG,     1'b1, 1'b0, 3'd0, 2'd0, 3'd1};
    vec[2]  = '{P_NSY,     1'b0, 1'b1, 3'd4, 2'd0, 3'd0};
    vec[3]  = '{P_EWG,     1'b0, 1'b1, 3'd3, 2'd0, 3'd0};
    vec[4]  = '{P_EWY,     1'b1, 1'b1, 3'd3, 2'd0, 3'd0};
    vec[5]  = '{6'b000000, 1'b0, 1'b1, 3'd2, 2'd0, 3'd0};
    vec[6]  = '{P_RED,     1'b0, 1'b1, 3'd2, 2'd0, 3'd0};
    vec[7]  = '{P_CON,     1'b0, 1'b1, 3'd1, 2'd0, 3'd0};
    vec[8]  = '{6'b010010, 1'b0, 1'b1, 3'd1, 2'd0, 3'd0};
    vec[9]  = '{6'b101001, 1'b0, 1'b1, 3'd2, 2'd0, 3'd0};
    vec[10] = '{6'b100011, 1'b1, 1'b1, 3'd1, 2'd0, 3'd0};
    vec[11] = '{6'b110001, 1'b0, 1'b1, 3'd2, 2'd0, 3'd0};

    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = P_NSG;
    tick = 0; fault_clr = 0; rst_n = 0;
    @(negedge clk);
    reset_all();
    chk("reset_fault", int'(fault), 0);
    chk("reset_code", int'(fault_code), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_cnt", int'(tick_cnt), 0);
    chk("reset_flash", int'(flash_y), 0);

    // Single-pattern table applied right after reset.
    for (int i = 0; i < 12; i++) begin
      step(P_NSG, 0, 0, 0);
      step(vec[i].lamps, vec[i].tck, 0, 1);
      chk($sformatf("vec%0d_fault", i), int'(fault), int'(vec[i].exp_fault));
      chk($sformatf("vec%0d_code", i), int'(fault_code), int'(vec[i].exp_code));
      chk($sformatf("vec%0d_phase", i), int'(phase), int'(vec[i].exp_phase));
      chk($sformatf("vec%0d_cnt", i), int'(tick_cnt), int'(vec[i].exp_cnt));
      $display("vec %0d lamps=%b tick=%0b -> fault=%0b code=%0d", i, vec[i].lamps, vec[i].tck,
               fault, fault_code);
    end

    // Healthy controller, tick every 10 cycles for 40 ticks.
    reset_all();
    peak = '{0, 0, 0, 0};
    last_phase = 0;
    any_fault = 0;
    for (int c = 0; c < 400; c++) begin
      ctrl_step((c % 10) == 9, 0, 1, 0);
      if (fault) any_fault = 1;
      if (int'(tick_cnt) > peak[phase]) peak[phase] = int'(tick_cnt);
      if (int'(phase) != last_phase) begin
        chk("phase_order", int'(phase), (last_phase + 1) % 4);
        last_phase = int'(phase);
      end
    end
    chk("healthy_fault", int'(any_fault), 0);
    for (int p = 0; p < 4; p++) chk($sformatf("peak%0d", p), peak[p], req_t[p]);
    $display("healthy run: peaks %0d/%0d/%0d/%0d", peak[0], peak[1], peak[2], peak[3]);

    // Conflict, flash toggling, sticky code, reset during fault.
    reset_all();
    step(P_NSG, 0, 0, 1);
    step(P_CON, 0, 0, 1);
    chk("con_fault", int'(fault), 1);
    chk("con_code", int'(fault_code), 1);
    chk("con_flash0", int'(flash_y), 1);
    step(P_NSG, 1, 0, 1);
    chk("con_flash1", int'(flash_y), 0);
    step(P_NSG, 0, 0, 1);
    chk("con_flash2", int'(flash_y), 0);
    step(P_NSG, 1, 0, 1);
    chk("con_flash3", int'(flash_y), 1);
    step(P_RED, 0, 0, 1);
    chk("con_sticky", int'(fault_code), 1);
    step(P_NSG, 0, 0, 0);
    chk("rstf_fault", int'(fault), 0);
    chk("rstf_phase", int'(phase), 0);
    chk("rstf_cnt", int'(tick_cnt), 0);
    chk("rstf_flash", int'(flash_y), 0);
    $display("conflict sequence done: code=%0d", fault_code);

    // Clear coinciding with a new conflict.
    step(P_NSG, 1, 0, 1);
    step(P_CON, 0, 0, 1);
    step(P_CON, 0, 1, 1);
    chk("clrcon_fault", int'(fault), 0);
    chk("clrcon_code", int'(fault_code), 0);
    step(P_CON, 0, 0, 1);
    chk("clrcon_refault", int'(fault), 1);
    chk("clrcon_recode", int'(fault_code), 1);
    $display("clear+conflict sequence: fault=%0b code=%0d", fault, fault_code);

    // Illegal all-red, clear, resync on fresh NS_G.
    reset_all();
    step(P_NSG, 1, 0, 1);
    step(P_RED, 0, 0, 1);
    chk("red_code", int'(fault_code), 2);
    chk("red_cnt_frozen", int'(tick_cnt), 1);
    step(P_EWY, 0, 1, 1);
    chk("red_clr_fault", int'(fault), 0);
    chk("red_clr_code", int'(fault_code), 0);
    chk("red_clr_cnt", int'(tick_cnt), 0);
    step(P_EWY, 1, 0, 1);
    step(P_NSG, 1, 0, 1);
    chk("resync_cnt", int'(tick_cnt), 1);
    for (int k = 0; k < 4; k++) step(P_NSG, 1, 0, 1);
    step(P_NSY, 0, 0, 1);
    chk("resync_run_fault", int'(fault), 0);
    chk("resync_run_phase", int'(phase), 1);
    $display("resync sequence: phase=%0d fault=%0b", phase, fault);

    // Early change after 3 ticks.
    reset_all();
    for (int k = 0; k < 3; k++) step(P_NSG, 1, 0, 1);
    step(P_NSY, 0, 0, 1);
    chk("early_code", int'(fault_code), 4);
    chk("early_cnt", int'(tick_cnt), 3);

    // Skipped phase.
    reset_all();
    for (int k = 0; k < 5; k++) step(P_NSG, 1, 0, 1);
    step(P_EWG, 0, 0, 1);
    chk("skip_code", int'(fault_code), 3);

    // Stuck in NS_G through a 6th tick.
    reset_all();
    for (int k = 0; k < 5; k++) step(P_NSG, 1, 0, 1);
    chk("stuck_pre_fault", int'(fault), 0);
    chk("stuck_pre_cnt", int'(tick_cnt), 5);
    step(P_NSG, 1, 0, 1);
    chk("stuck_code", int'(fault_code), 5);
    chk("stuck_cnt", int'(tick_cnt), 5);
    $display("duration sequences done");

    // Randomized run with glitches, clears and occasional resets.
    reset_all();
    for (int c = 0; c < 4000; c++) begin
      ctrl_step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 999) != 0, $urandom_range(0, 149) == 0);
    end
    $display("random run done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
